// File: rtl/qspi_pkg.sv
// Shared types and widths for the QSPI fetch scheduler.
//   QSPI_ADDR_W   flash byte-address width
//   QSPI_DATA_W   fetch result width
//   fetch_state_t scheduler FSM state
package qspi_pkg;

  localparam int unsigned QSPI_ADDR_W = 24;
  localparam int unsigned QSPI_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    WAIT
  } fetch_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   i_req  request vector
//   i_ptr  index of the last winner; priority starts at i_ptr+1
//   o_gnt  one-hot grant, all-zero when no request
module rr_arbiter #(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [NREQ-1:0]         o_gnt
);

  localparam int unsigned IdW = $clog2(NREQ);

  logic [IdW-1:0] w_idx;
  logic           w_found;

  // Walk the ring starting just after the pointer; first requester wins.
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      w_idx = IdW'((32'(i_ptr) + i) % NREQ);
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/qspi_fetch_scheduler.sv
// Shares the qspi_top word-fetch path between NREQ requesters. One request
// is latched at a time, issued only while fetch_window is high, and its
// result returned after FETCH_LATENCY cycles. A window drop during the wait
// aborts the attempt; after MAX_RETRIES aborts an error response is sent.
//   clk, rst_n              clock, async active-low reset
//   req, req_addr           per-requester request level and byte address
//   ack                     one-hot capture pulse
//   rsp_valid/id/data/err   response pulse, owner, data, retries-exhausted
//   fetch_window            fetches allowed while high
//   fetch, fetch_addr       fetch pulse and held address to qspi_top
//   fetch_result            data from qspi_top
//   busy                    a request is latched
module qspi_fetch_scheduler
  import qspi_pkg::*;
#(
  parameter int unsigned NREQ          = 2,
  parameter int unsigned FETCH_LATENCY = 24,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NREQ-1:0]                     req,
  input  logic [NREQ-1:0][QSPI_ADDR_W-1:0]    req_addr,
  output logic [NREQ-1:0]                     ack,
  output logic                                rsp_valid,
  output logic [$clog2(NREQ)-1:0]             rsp_id,
  output logic [QSPI_DATA_W-1:0]              rsp_data,
  output logic                                rsp_err,
  input  logic                                fetch_window,
  output logic                                fetch,
  output logic [QSPI_ADDR_W-1:0]              fetch_addr,
  input  logic [QSPI_DATA_W-1:0]              fetch_result,
  output logic                                busy
);

  localparam int unsigned IdW  = $clog2(NREQ);
  localparam int unsigned CntW = $clog2(FETCH_LATENCY + 1);
  localparam int unsigned RtyW = $clog2(MAX_RETRIES + 1);

  fetch_state_t r_state, w_state_d;

  logic [IdW-1:0]         r_ptr, w_ptr_d;
  logic [IdW-1:0]         r_rsp_id, w_rsp_id_d;
  logic [CntW-1:0]        r_cnt, w_cnt_d;
  logic [RtyW-1:0]        r_rty, w_rty_d, w_rty_inc;
  logic [NREQ-1:0]        r_ack, w_ack_d;
  logic                   r_fetch, w_fetch_d;
  logic [QSPI_ADDR_W-1:0] r_fetch_addr, w_fetch_addr_d;
  logic                   r_rsp_valid, w_rsp_valid_d;
  logic                   r_rsp_err, w_rsp_err_d;
  logic [QSPI_DATA_W-1:0] r_rsp_data, w_rsp_data_d;

  logic [NREQ-1:0]        w_gnt;
  logic [IdW-1:0]         w_win;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt)
  );

  always_comb begin
    w_win = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) w_win = IdW'(i);
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_ptr_d        = r_ptr;
    w_rsp_id_d     = r_rsp_id;
    w_cnt_d        = r_cnt;
    w_rty_d        = r_rty;
    w_ack_d        = '0;
    w_fetch_d      = 1'b0;
    w_fetch_addr_d = r_fetch_addr;
    w_rsp_valid_d  = 1'b0;
    w_rsp_err_d    = 1'b0;
    w_rsp_data_d   = r_rsp_data;
    w_rty_inc      = (r_rty == RtyW'(MAX_RETRIES)) ? r_rty : r_rty + RtyW'(1);

    unique case (r_state)
      IDLE: begin
        if (|req) begin
          w_ack_d        = w_gnt;
          w_ptr_d        = w_win;
          w_rsp_id_d     = w_win;
          w_fetch_addr_d = req_addr[w_win];
          w_rty_d        = '0;
          w_state_d      = PEND;
        end
      end
      PEND: begin
        if (fetch_window) begin
          w_fetch_d = 1'b1;
          w_cnt_d   = CntW'(FETCH_LATENCY);
          w_state_d = WAIT;
        end
      end
      WAIT: begin
        // Hold the count during the fetch pulse so it reaches 1 in exactly
        // the cycle fetch_result becomes valid.
        if (!r_fetch && (r_cnt != '0)) w_cnt_d = r_cnt - CntW'(1);
        if (!fetch_window) begin
          w_rty_d = w_rty_inc;
          if (w_rty_inc == RtyW'(MAX_RETRIES)) begin
            w_rsp_valid_d = 1'b1;
            w_rsp_err_d   = 1'b1;
            w_rsp_data_d  = '0;
            w_state_d     = IDLE;
          end else begin
            w_state_d = PEND;
          end
        end else if (r_cnt == CntW'(1)) begin
          w_rsp_valid_d = 1'b1;
          w_rsp_data_d  = fetch_result;
          w_state_d     = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_ptr        <= IdW'(NREQ - 1);
      r_rsp_id     <= '0;
      r_cnt        <= '0;
      r_rty        <= '0;
      r_ack        <= '0;
      r_fetch      <= 1'b0;
      r_fetch_addr <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_data   <= '0;
    end else begin
      r_state      <= w_state_d;
      r_ptr        <= w_ptr_d;
      r_rsp_id     <= w_rsp_id_d;
      r_cnt        <= w_cnt_d;
      r_rty        <= w_rty_d;
      r_ack        <= w_ack_d;
      r_fetch      <= w_fetch_d;
      r_fetch_addr <= w_fetch_addr_d;
      r_rsp_valid  <= w_rsp_valid_d;
      r_rsp_err    <= w_rsp_err_d;
      r_rsp_data   <= w_rsp_data_d;
    end
  end

  assign ack        = r_ack;
  assign fetch      = r_fetch;
  assign fetch_addr = r_fetch_addr;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_err    = r_rsp_err;
  assign rsp_data   = r_rsp_data;
  assign rsp_id     = r_rsp_id;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_qspi_fetch_scheduler.sv
// Directed bench for qspi_fetch_scheduler with NREQ=2, FETCH_LATENCY=24,
// MAX_RETRIES=3. A small qspi_top model drives m_data on fetch_result
// exactly FETCH_LATENCY cycles after each fetch pulse, and garbage otherwise.
module tb_qspi_fetch_scheduler;

  localparam int unsigned LAT  = 24;
  localparam int unsigned MAXR = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req;
  logic [1:0][23:0] req_addr;
  logic [1:0]       ack;
  logic             rsp_valid;
  logic [0:0]       rsp_id;
  logic [31:0]      rsp_data;
  logic             rsp_err;
  logic             fetch_window;
  logic             fetch;
  logic [23:0]      fetch_addr;
  logic [31:0]      fetch_result;
  logic             busy;

  logic [31:0]      m_data;
  int unsigned      m_age = 0;

  int n_checks = 0;
  int n_errors = 0;

  qspi_fetch_scheduler #(
    .NREQ          (2),
    .FETCH_LATENCY (LAT),
    .MAX_RETRIES   (MAXR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_addr     (req_addr),
    .ack          (ack),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .fetch_window (fetch_window),
    .fetch        (fetch),
    .fetch_addr   (fetch_addr),
    .fetch_result (fetch_result),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // age = cycles since the fetch pulse; result valid when age == LAT
  always @(posedge clk) begin
    if (fetch) m_age <= 1;
    else if (m_age != 0 && m_age < 1000) m_age <= m_age + 1;
  end
  assign fetch_result = (m_age == LAT) ? m_data : 32'h5A5A_5A5A;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig_now(input int sel);
    case (sel)
      0:       return |ack;
      1:       return fetch;
      default: return rsp_valid;
    endcase
  endfunction

  // Steps until the selected output is high or the bound expires.
  task automatic wait_for(input string tag, input int sel, input int bound, output int n);
    n = 0;
    while (!sig_now(sel) && n < bound) begin
      step();
      n++;
    end
    check_eq({tag, "_seen"}, 32'(sig_now(sel)), 32'd1);
  endtask

  logic [1:0]  exp_ack [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
  logic [23:0] exp_addr[4] = '{24'h222222, 24'h111111, 24'h222222, 24'h111111};

  initial begin
    int n;
    int cnt;

    rst_n        = 1'b0;
    req          = '0;
    req_addr     = '0;
    fetch_window = 1'b0;
    m_data       = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_ctl", 32'({fetch, rsp_valid, rsp_err, busy}), 32'd0);
    check_eq("rst_addr", 32'(fetch_addr), 32'd0);
    check_eq("rst_data", rsp_data, 32'd0);
    check_eq("rst_id", 32'(rsp_id), 32'd0);
    rst_n = 1'b1;
    step();

    // Single request, window open: ack@1, fetch@2, rsp@27
    fetch_window = 1'b1;
    m_data       = 32'hDEAD_BEEF;
    req_addr[0]  = 24'h00ABCD;
    req          = 2'b01;
    step();
    check_eq("t1_ack", 32'(ack), 32'd1);
    check_eq("t1_busy", 32'(busy), 32'd1);
    req = 2'b00;
    step();
    check_eq("t1_fetch", 32'(fetch), 32'd1);
    check_eq("t1_faddr", 32'(fetch_addr), 32'h00ABCD);
    cnt = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      cnt += int'(rsp_valid);
    end
    check_eq("t1_early_rsp", 32'(cnt), 32'd0);
    step();
    check_eq("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("t1_rsp_id", 32'(rsp_id), 32'd0);
    check_eq("t1_rsp_data", rsp_data, 32'hDEAD_BEEF);
    check_eq("t1_rsp_err", 32'(rsp_err), 32'd0);
    step();
    check_eq("t1_idle", 32'({rsp_valid, busy}), 32'd0);

    // Fairness: both held, last winner was 0
    req_addr[0] = 24'h111111;
    req_addr[1] = 24'h222222;
    m_data      = 32'h0000_F00D;
    req         = 2'b11;
    step();
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("t2_ack%0d", k), 32'(ack), 32'(exp_ack[k]));
      check_eq($sformatf("t2_addr%0d", k), 32'(fetch_addr), 32'(exp_addr[k]));
      wait_for($sformatf("t2_rsp%0d", k), 2, 60, n);
      check_eq($sformatf("t2_lat%0d", k), 32'(n), 32'd26);
      check_eq($sformatf("t2_id%0d", k), 32'(rsp_id), 32'(k % 2 == 0 ? 1 : 0));
      if (k == 3) req = 2'b00;
      step();
    end
    check_eq("t2_no_ack", 32'(ack), 32'd0);

    // Window closed at request, opened 40 cycles later
    fetch_window = 1'b0;
    m_data       = 32'h1234_5678;
    req_addr[0]  = 24'h0C0C0C;
    req          = 2'b01;
    step();
    check_eq("t3_ack", 32'(ack), 32'd1);
    req = 2'b00;
    cnt = 0;
    for (int i = 0; i < 39; i++) begin
      step();
      cnt += int'(fetch);
    end
    check_eq("t3_no_fetch", 32'(cnt), 32'd0);
    fetch_window = 1'b1;
    step();
    check_eq("t3_fetch", 32'(fetch), 32'd1);
    wait_for("t3_rsp", 2, 60, n);
    check_eq("t3_lat", 32'(n), 32'd25);
    check_eq("t3_data", rsp_data, 32'h1234_5678);
    check_eq("t3_err", 32'(rsp_err), 32'd0);

    // Single abort mid-WAIT, retried in the next window
    step();
    m_data      = 32'hCAFE_F00D;
    req_addr[1] = 24'h0F0F0F;
    req         = 2'b10;
    step();
    check_eq("t4_ack", 32'(ack), 32'd2);
    req = 2'b00;
    step();
    check_eq("t4_fetch1", 32'(fetch), 32'd1);
    repeat (10) step();
    fetch_window = 1'b0;
    step();
    fetch_window = 1'b1;
    check_eq("t4_abort_busy", 32'({fetch, rsp_valid, busy}), 32'd1);
    step();
    check_eq("t4_fetch2", 32'(fetch), 32'd1);
    check_eq("t4_faddr2", 32'(fetch_addr), 32'h0F0F0F);
    wait_for("t4_rsp", 2, 60, n);
    check_eq("t4_lat", 32'(n), 32'd25);
    check_eq("t4_data", rsp_data, 32'hCAFE_F00D);
    check_eq("t4_err", 32'(rsp_err), 32'd0);
    check_eq("t4_id", 32'(rsp_id), 32'd1);

    // Retries exhausted, then requester 1 acked
    step();
    req_addr[0] = 24'h111111;
    req_addr[1] = 24'h222222;
    req         = 2'b11;
    step();
    check_eq("t5_ack", 32'(ack), 32'd1);
    req = 2'b10;
    cnt = 0;
    for (int a = 0; a < 3; a++) begin
      wait_for($sformatf("t5_fetch%0d", a), 1, 10, n);
      cnt++;
      check_eq($sformatf("t5_faddr%0d", a), 32'(fetch_addr), 32'h111111);
      repeat (5) step();
      fetch_window = 1'b0;
      step();
      fetch_window = 1'b1;
      if (a < 2) check_eq($sformatf("t5_norsp%0d", a), 32'(rsp_valid), 32'd0);
    end
    check_eq("t5_nfetch", 32'(cnt), 32'd3);
    check_eq("t5_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("t5_rsp_err", 32'(rsp_err), 32'd1);
    check_eq("t5_rsp_data", rsp_data, 32'd0);
    check_eq("t5_rsp_id", 32'(rsp_id), 32'd0);
    step();
    check_eq("t5_next_ack", 32'(ack), 32'd2);

    // Reset mid-WAIT with req[1] still held
    m_data = 32'h600D_D00D;
    step();
    check_eq("t6_fetch", 32'(fetch), 32'd1);
    repeat (5) step();
    rst_n = 1'b0;
    #2;
    check_eq("t6_rst_ctl", 32'({ack, fetch, rsp_valid, rsp_err, busy}), 32'd0);
    check_eq("t6_rst_addr", 32'(fetch_addr), 32'd0);
    check_eq("t6_rst_id", 32'(rsp_id), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check_eq("t6_reack", 32'(ack), 32'd2);
    req = 2'b00;
    wait_for("t6_rsp", 2, 60, n);
    check_eq("t6_lat", 32'(n), 32'd26);
    check_eq("t6_data", rsp_data, 32'h600D_D00D);
    check_eq("t6_id", 32'(rsp_id), 32'd1);
    check_eq("t6_err", 32'(rsp_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
